// File: rtl/axi_slave_mem_pkg.sv
// Shared response codes and FSM state types for the AXI4 memory responder.
package axi_slave_mem_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

endpackage

// File: rtl/axi_slave_mem_ram.sv
// Word memory: byte-enabled synchronous write port, asynchronous read port.
module axi_slave_mem_ram #(
  parameter int MEM_WORDS = 256,
  parameter int IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic             c,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wstrb,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [MEM_WORDS];

  // Contents deliberately have no reset so data survives a bus reset.
  always_ff @(posedge c) begin
    for (int b = 0; b < 4; b++) begin
      if (we && wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 slave responder with internal word memory; independent write and read
// FSMs, one outstanding INCR burst per direction.
module axi_slave_mem
  import axi_slave_mem_pkg::*;
#(
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 256
) (
  input  logic              c,
  input  logic              rn,
  input  logic [ID_W-1:0]   awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [7:0]        awlen,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [ID_W-1:0]   arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [7:0]        arlen,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  wr_state_t        wr_state;
  rd_state_t        rd_state;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] rd_addr;
  logic [7:0]       wr_len;
  logic [7:0]       rd_len;
  logic [7:0]       rd_beat;
  logic [8:0]       wr_beats;
  logic             wr_en;
  logic [31:0]      mem_rdata;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{awaddr, araddr};

  assign wr_en = wvalid & wready;
  // In idle the AR address feeds the first beat; otherwise prefetch the next word.
  assign rd_addr = (rd_state == R_IDLE) ? araddr[2 +: IDX_W] : rd_idx + 1'b1;
  assign rresp   = AXI_RESP_OKAY;

  axi_slave_mem_ram #(
    .MEM_WORDS (MEM_WORDS),
    .IDX_W     (IDX_W)
  ) u_ram (
    .c     (c),
    .we    (wr_en),
    .waddr (wr_idx),
    .wdata (wdata),
    .wstrb (wstrb),
    .raddr (rd_addr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      wr_state <= W_IDLE;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bresp    <= AXI_RESP_OKAY;
      bid      <= '0;
      wr_idx   <= '0;
      wr_len   <= '0;
      wr_beats <= '0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          awready <= 1'b1;
          if (awvalid && awready) begin
            awready  <= 1'b0;
            wready   <= 1'b1;
            bid      <= awid;
            wr_idx   <= awaddr[2 +: IDX_W];
            wr_len   <= awlen;
            wr_beats <= '0;
            wr_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (wvalid && wready) begin
            wr_idx <= wr_idx + 1'b1;
            // Saturating so an overlong burst can never alias back to a match.
            if (wr_beats != 9'h1FF) wr_beats <= wr_beats + 9'd1;
            if (wlast) begin
              wready   <= 1'b0;
              bvalid   <= 1'b1;
              bresp    <= (wr_beats == {1'b0, wr_len}) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
              wr_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid   <= 1'b0;
            awready  <= 1'b1;
            wr_state <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      rd_state <= R_IDLE;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rlast    <= 1'b0;
      rdata    <= '0;
      rid      <= '0;
      rd_idx   <= '0;
      rd_len   <= '0;
      rd_beat  <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          arready <= 1'b1;
          if (arvalid && arready) begin
            arready  <= 1'b0;
            rid      <= arid;
            rd_idx   <= araddr[2 +: IDX_W];
            rd_len   <= arlen;
            rd_beat  <= '0;
            rvalid   <= 1'b1;
            rdata    <= mem_rdata;
            rlast    <= (arlen == 8'd0);
            rd_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (rvalid && rready) begin
            if (rlast) begin
              rvalid   <= 1'b0;
              rlast    <= 1'b0;
              arready  <= 1'b1;
              rd_state <= R_IDLE;
            end else begin
              rd_idx  <= rd_idx + 1'b1;
              rd_beat <= rd_beat + 8'd1;
              rdata   <= mem_rdata;
              rlast   <= ((rd_beat + 8'd1) == rd_len);
            end
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Self-checking bench for axi_slave_mem: directed spec bursts, a vector table
// and randomized bursts checked against a word-array memory model.
module tb_axi_slave_mem;
  import axi_slave_mem_pkg::*;

  localparam int ID_W      = 4;
  localparam int ADDR_W    = 32;
  localparam int MEM_WORDS = 256;

  logic              c = 1'b0;
  logic              rn = 1'b1;
  logic [ID_W-1:0]   awid = '0;
  logic [ADDR_W-1:0] awaddr = '0;
  logic [7:0]        awlen = '0;
  logic              awvalid = 1'b0;
  logic              awready;
  logic [31:0]       wdata = '0;
  logic [3:0]        wstrb = '0;
  logic              wlast = 1'b0;
  logic              wvalid = 1'b0;
  logic              wready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready = 1'b0;
  logic [ID_W-1:0]   arid = '0;
  logic [ADDR_W-1:0] araddr = '0;
  logic [7:0]        arlen = '0;
  logic              arvalid = 1'b0;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready = 1'b0;

  always #5 c = ~c;

  axi_slave_mem #(.ID_W(ID_W), .ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS)) dut (
    .c(c), .rn(rn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    int          len;
    int          beats;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_mem [MEM_WORDS];
  logic [31:0] burst_data [512];
  vec_t        vecs [6];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timed_out(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got timeout expected handshake", name);
  endtask

  task automatic tick;
    @(posedge c);
    #1;
  endtask

  function automatic int word_of(input logic [31:0] addr, input int offset);
    return (int'(addr / 4) + offset) % MEM_WORDS;
  endfunction

  // Drives one write burst; the model is updated per accepted beat.
  task automatic apply_stimulus(input logic [3:0] id, input logic [31:0] addr, input int len,
                                input int beats, input logic [3:0] strb,
                                input logic [1:0] exp_resp, input bit gaps);
    int n;
    int w;
    awid = id; awaddr = addr; awlen = 8'(len); awvalid = 1'b1;
    n = 0;
    while (!awready && n < 100) begin tick; n++; end
    if (!awready) begin timed_out("aw_handshake"); awvalid = 1'b0; return; end
    tick;
    awvalid = 1'b0;
    check_output("wready_1cyc_after_aw", 32'(wready), 32'd1);
    check_output("awready_low_in_burst", 32'(awready), 32'd0);
    for (int i = 0; i < beats; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin wvalid = 1'b0; tick; end
      wvalid = 1'b1; wdata = burst_data[i]; wstrb = strb; wlast = (i == beats - 1);
      n = 0;
      while (!wready && n < 20) begin tick; n++; end
      if (!wready) begin timed_out("w_handshake"); wvalid = 1'b0; wlast = 1'b0; return; end
      w = word_of(addr, i);
      for (int b = 0; b < 4; b++)
        if (strb[b]) model_mem[w][8*b +: 8] = burst_data[i][8*b +: 8];
      tick;
    end
    wvalid = 1'b0; wlast = 1'b0;
    check_output("bvalid_1cyc_after_wlast", 32'(bvalid), 32'd1);
    check_output("wready_low_after_wlast", 32'(wready), 32'd0);
    check_output("bid", 32'(bid), 32'(id));
    check_output("bresp", 32'(bresp), 32'(exp_resp));
    if (gaps) begin
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) begin
        tick;
        check_output("bvalid_held", 32'(bvalid), 32'd1);
        check_output("bresp_held", 32'(bresp), 32'(exp_resp));
      end
    end
    bready = 1'b1;
    tick;
    bready = 1'b0;
    check_output("bvalid_low_after_bready", 32'(bvalid), 32'd0);
    check_output("awready_after_bready", 32'(awready), 32'd1);
  endtask

  // Reads a burst; mode 0 rready=1, 1 alternating 1,0,..., 2 random.
  // abort_at>=0 returns while that beat is presented, without accepting it.
  task automatic check_output_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                                    input int mode, input int abort_at);
    int n;
    int beat;
    int cyc;
    arid = id; araddr = addr; arlen = 8'(len); arvalid = 1'b1;
    n = 0;
    while (!arready && n < 100) begin tick; n++; end
    if (!arready) begin timed_out("ar_handshake"); arvalid = 1'b0; return; end
    tick;
    arvalid = 1'b0;
    check_output("rvalid_1cyc_after_ar", 32'(rvalid), 32'd1);
    check_output("arready_low_in_burst", 32'(arready), 32'd0);
    beat = 0; cyc = 0;
    while (beat <= len && cyc < 2000) begin
      if (beat == abort_at) return;
      rready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      check_output("rvalid", 32'(rvalid), 32'd1);
      check_output("rdata", rdata, model_mem[word_of(addr, beat)]);
      check_output("rlast", 32'(rlast), 32'(beat == len));
      check_output("rid", 32'(rid), 32'(id));
      check_output("rresp", 32'(rresp), 32'(AXI_RESP_OKAY));
      tick;
      if (rready) beat++;
      cyc++;
    end
    rready = 1'b0;
    if (beat <= len) begin timed_out("r_burst"); return; end
    if (mode == 1) check_output("alt_stall_cycles", 32'(cyc), 32'(2 * len + 1));
    check_output("rvalid_low_after_rlast", 32'(rvalid), 32'd0);
    check_output("arready_after_rlast", 32'(arready), 32'd1);
  endtask

  initial begin
    int len;
    int beats;
    logic [1:0] resp;
    logic [31:0] addr;

    vecs[0] = '{4'd2, 32'h44A0_0100, 3,  4,  4'hF, AXI_RESP_OKAY};
    vecs[1] = '{4'd3, 32'h0000_03F8, 3,  4,  4'hF, AXI_RESP_OKAY};
    vecs[2] = '{4'd4, 32'h44A0_0200, 0,  1,  4'h5, AXI_RESP_OKAY};
    vecs[3] = '{4'd5, 32'h44A0_0300, 7,  4,  4'hF, AXI_RESP_SLVERR};
    vecs[4] = '{4'd6, 32'h44A0_0340, 1,  3,  4'hF, AXI_RESP_SLVERR};
    vecs[5] = '{4'd7, 32'h44A0_0380, 15, 16, 4'hC, AXI_RESP_OKAY};

    #3 rn = 1'b0;
    #1;
    check_output("reset_awready", 32'(awready), 32'd0);
    check_output("reset_wready", 32'(wready), 32'd0);
    check_output("reset_arready", 32'(arready), 32'd0);
    check_output("reset_bvalid", 32'(bvalid), 32'd0);
    check_output("reset_rvalid", 32'(rvalid), 32'd0);
    check_output("reset_rlast", 32'(rlast), 32'd0);
    check_output("reset_bresp", 32'(bresp), 32'd0);
    check_output("reset_bid_rid", 32'({bid, rid}), 32'd0);
    check_output("reset_rdata", rdata, 32'd0);
    tick; tick;
    rn = 1'b1;
    tick;
    check_output("post_reset_awready", 32'(awready), 32'd1);
    check_output("post_reset_arready", 32'(arready), 32'd1);

    // Fill the whole memory so every later read has a known model value.
    for (int blk = 0; blk < MEM_WORDS / 16; blk++) begin
      for (int i = 0; i < 16; i++) burst_data[i] = $urandom;
      apply_stimulus(4'(blk), 32'(blk * 64), 15, 16, 4'hF, AXI_RESP_OKAY, 1'b0);
    end

    $display("[TB] spec burst at 0x44A00000");
    for (int i = 0; i < 8; i++) burst_data[i] = (i % 2 == 0) ? 32'h0123_4567 : 32'h89AB_CDEF;
    apply_stimulus(4'd1, 32'h44A0_0000, 7, 8, 4'hF, AXI_RESP_OKAY, 1'b0);
    check_output_burst(4'd1, 32'h44A0_0000, 7, 0, -1);
    check_output_burst(4'd1, 32'h44A0_0000, 7, 1, -1);

    $display("[TB] partial strobe merge");
    burst_data[0] = 32'h1234_5678;
    apply_stimulus(4'd9, 32'h44A0_0400, 0, 1, 4'hF, AXI_RESP_OKAY, 1'b0);
    burst_data[0] = 32'hDEAD_BEEF;
    apply_stimulus(4'd9, 32'h44A0_0400, 0, 1, 4'h3, AXI_RESP_OKAY, 1'b0);
    check_output_burst(4'd9, 32'h44A0_0400, 0, 0, -1);

    $display("[TB] read wrap at last word");
    check_output_burst(4'd10, 32'h0000_03FC, 1, 0, -1);

    $display("[TB] vector table");
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < vecs[v].beats; i++) burst_data[i] = $urandom;
      apply_stimulus(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].beats,
                     vecs[v].strb, vecs[v].exp_resp, 1'b1);
      len = (vecs[v].beats - 1 > vecs[v].len) ? vecs[v].beats - 1 : vecs[v].len;
      check_output_burst(vecs[v].id, vecs[v].addr, len, v % 3, -1);
    end

    $display("[TB] reset during read beat 4");
    check_output_burst(4'd11, 32'h44A0_0000, 7, 0, 4);
    rready = 1'b0;
    #2 rn = 1'b0;
    #1;
    check_output("midburst_reset_rvalid", 32'(rvalid), 32'd0);
    check_output("midburst_reset_arready", 32'(arready), 32'd0);
    check_output("midburst_reset_rdata", rdata, 32'd0);
    tick;
    rn = 1'b1;
    tick;
    check_output("release_arready", 32'(arready), 32'd1);
    check_output("release_awready", 32'(awready), 32'd1);
    check_output_burst(4'd11, 32'h44A0_0000, 7, 0, -1);

    $display("[TB] randomized bursts");
    for (int t = 0; t < 24; t++) begin
      len = $urandom_range(0, 15);
      beats = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len + 2) : len + 1;
      resp = (beats == len + 1) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      addr = $urandom;
      for (int i = 0; i < beats; i++) burst_data[i] = $urandom;
      apply_stimulus(4'($urandom), addr, len, beats, 4'($urandom), resp, 1'b1);
      check_output_burst(4'($urandom), $urandom, $urandom_range(0, 15), 2, -1);
      check_output_burst(4'($urandom), addr, beats - 1, 2, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
